// File: rtl/raymarch_frame_scheduler.sv
// Frame driver for the raymarcher. Sweeps pixels under a credit limit, re-times the
// results through a valid delay line and buffers them in a FIFO toward the framebuffer.
module raymarch_frame_scheduler #(
  parameter int CORDW         = 10,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int PIPE_LATENCY  = 24,
  parameter int FIFO_DEPTH    = 32,
  parameter int FB_ADDR_W     = 19
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 frame_done,
  input  logic [26:0]          cam_look_at_1_1,
  input  logic [26:0]          cam_look_at_1_2,
  input  logic [26:0]          cam_look_at_1_3,
  input  logic [26:0]          cam_look_at_2_1,
  input  logic [26:0]          cam_look_at_2_2,
  input  logic [26:0]          cam_look_at_2_3,
  input  logic [26:0]          cam_look_at_3_1,
  input  logic [26:0]          cam_look_at_3_2,
  input  logic [26:0]          cam_look_at_3_3,
  input  logic [26:0]          cam_eye_x,
  input  logic [26:0]          cam_eye_y,
  input  logic [26:0]          cam_eye_z,
  output logic [26:0]          rm_look_at_1_1,
  output logic [26:0]          rm_look_at_1_2,
  output logic [26:0]          rm_look_at_1_3,
  output logic [26:0]          rm_look_at_2_1,
  output logic [26:0]          rm_look_at_2_2,
  output logic [26:0]          rm_look_at_2_3,
  output logic [26:0]          rm_look_at_3_1,
  output logic [26:0]          rm_look_at_3_2,
  output logic [26:0]          rm_look_at_3_3,
  output logic [26:0]          rm_eye_x,
  output logic [26:0]          rm_eye_y,
  output logic [26:0]          rm_eye_z,
  output logic [CORDW-1:0]     rm_pixel_x,
  output logic [CORDW-1:0]     rm_pixel_y,
  input  logic [7:0]           rm_red,
  input  logic [7:0]           rm_green,
  input  logic [7:0]           rm_blue,
  output logic                 fb_valid,
  input  logic                 fb_ready,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [23:0]          fb_data
);

  // state | meaning
  // IDLE  | waiting for start, camera registers hold last frame's values
  // ISSUE | sweeping pixels into the raymarcher while credit allows
  // DRAIN | all pixels issued, waiting for the last result to hand off
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  localparam int PTRW      = $clog2(FIFO_DEPTH);
  localparam int INFW      = $clog2(PIPE_LATENCY + 1);
  localparam int LAST_ADDR = SCREEN_WIDTH * SCREEN_HEIGHT - 1;

  state_t                  state;
  logic [CORDW-1:0]        cx, cy, held_x, held_y;
  logic [PIPE_LATENCY-1:0] dl;
  logic [INFW-1:0]         inflight;
  logic [23:0]             mem [FIFO_DEPTH];
  logic [PTRW-1:0]         rd_ptr, wr_ptr;
  logic [PTRW:0]           fifo_count;
  logic                    issue_ok, push, pop, last_pix;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < PIPE_LATENCY; i++) inflight = inflight + INFW'(dl[i]);
  end

  // Credit covers every result that could still land in the FIFO, so a push never overflows.
  assign issue_ok   = (state == ISSUE) && (int'(fifo_count) + int'(inflight) < FIFO_DEPTH);
  assign push       = dl[PIPE_LATENCY-1];
  assign fb_valid   = (fifo_count != '0);
  assign pop        = fb_valid && fb_ready;
  assign fb_data    = fb_valid ? mem[rd_ptr] : '0;
  assign last_pix   = (cx == CORDW'(SCREEN_WIDTH - 1)) && (cy == CORDW'(SCREEN_HEIGHT - 1));
  assign frame_done = (state == DRAIN) && pop && (fb_addr == FB_ADDR_W'(LAST_ADDR));
  assign busy       = (state != IDLE);
  assign rm_pixel_x = issue_ok ? cx : held_x;
  assign rm_pixel_y = issue_ok ? cy : held_y;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cx     <= '0;
      cy     <= '0;
      held_x <= '0;
      held_y <= '0;
      fb_addr <= '0;
      {rm_look_at_1_1, rm_look_at_1_2, rm_look_at_1_3,
       rm_look_at_2_1, rm_look_at_2_2, rm_look_at_2_3,
       rm_look_at_3_1, rm_look_at_3_2, rm_look_at_3_3,
       rm_eye_x, rm_eye_y, rm_eye_z} <= '0;
    end else begin
      if (pop) fb_addr <= fb_addr + 1'b1;
      case (state)
        IDLE: if (start) begin
          state   <= ISSUE;
          cx      <= '0;
          cy      <= '0;
          fb_addr <= '0;
          {rm_look_at_1_1, rm_look_at_1_2, rm_look_at_1_3,
           rm_look_at_2_1, rm_look_at_2_2, rm_look_at_2_3,
           rm_look_at_3_1, rm_look_at_3_2, rm_look_at_3_3,
           rm_eye_x, rm_eye_y, rm_eye_z} <=
            {cam_look_at_1_1, cam_look_at_1_2, cam_look_at_1_3,
             cam_look_at_2_1, cam_look_at_2_2, cam_look_at_2_3,
             cam_look_at_3_1, cam_look_at_3_2, cam_look_at_3_3,
             cam_eye_x, cam_eye_y, cam_eye_z};
        end
        ISSUE: if (issue_ok) begin
          held_x <= cx;
          held_y <= cy;
          if (last_pix) state <= DRAIN;
          if (cx == CORDW'(SCREEN_WIDTH - 1)) begin
            cx <= '0;
            cy <= cy + 1'b1;
          end else begin
            cx <= cx + 1'b1;
          end
        end
        DRAIN: if (frame_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dl         <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      dl <= (dl << 1) | PIPE_LATENCY'(issue_ok);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {rm_red, rm_green, rm_blue};
  end

endmodule
